bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential packed-BCD to binary converter (reverse double-dabble): the inverse of the
//  binary-to-BCD path that feeds the 7-segment display. Converts operator-entered decimal
//  digits (switch/keypad BCD) into a binary word for the FIR datapath, one bit per clock,
//  with start/busy/done handshake and invalid-digit detection.
// PARAMETERS
//  NUM_DIGITS  9   number of packed BCD digits on bcd_in (digit 0 = bits [3:0], least significant)
//  OUT_W       30  binary result width; must satisfy 2**OUT_W > 10**NUM_DIGITS - 1
// PORTS
//  CLOCK_50  in   1               system clock, all logic on posedge
//  rst       in   1               asynchronous, active-high reset
//  start     in   1               request conversion; sampled only in IDLE
//  bcd_in    in   4*NUM_DIGITS    packed BCD operand, captured on the start edge
//  busy      out  1               high from the edge after start is accepted until done
//  done      out  1               one-cycle pulse: data_out/err valid and updated
//  err       out  1               set with done when any captured digit > 9; held until next done
//  data_out  out  OUT_W (+1)      binary result, held until next done (OUT_W+1 wide with BCD2BIN_SIGNED_EN)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0, err=0, data_out=0; shift reg and counter cleared.
//  - FSM: IDLE -> CHECK -> SHIFT -> DONE -> IDLE.
//    IDLE : busy=0. start=1 at edge -> capture bcd_in into BCD field, binary field=0, goto CHECK.
//    CHECK: busy=1, one cycle. Any digit > 4'd9 -> goto DONE with error; else goto SHIFT, cnt=0.
//    SHIFT: busy=1, exactly OUT_W cycles. Each cycle: shift {bcd,bin} right 1 (bcd LSB -> bin MSB),
//           then every BCD digit >= 8 has 3 subtracted (4-bit, no borrow across digits).
//           cnt counts 0..OUT_W-1; on cnt==OUT_W-1 goto DONE.
//    DONE : busy=0, done=1 for this cycle only; data_out=bin field (0 on error), err=error flag; goto IDLE.
//  - Latency: start sampled at edge k -> done high in cycle after edge k+OUT_W+1 (OUT_W+2 edges);
//    error path: done after edge k+1 (2 edges). Throughput: one conversion per OUT_W+3 cycles;
//    start held high re-triggers on the IDLE cycle following DONE.
//  - start while busy or in DONE: ignored, no queuing; bcd_in changes after capture ignored.
//  - Output registers change only in DONE; data_out/err stable between done pulses.
//  - Reset mid-conversion: immediate abort, no done pulse, data_out forced to 0.
//  - Value 0 converts to 0 with err=0; max 10**NUM_DIGITS-1 exact (width rule above, no overflow).
// CONFIGURATION
//  BCD2BIN_SIGNED_EN defined: extra input sign_in (1 bit, captured with bcd_in); data_out is
//    OUT_W+1 bits two's complement; sign_in=1 -> data_out = -magnitude; magnitude 0 -> data_out=0
//    (no negative zero); err path -> data_out=0 regardless of sign_in. Latency unchanged.
//  Not defined: no sign_in port; data_out OUT_W bits unsigned.
// TESTING  (NUM_DIGITS=3, OUT_W=10 unless noted)
//  1. rst pulse, bcd_in=12'h255, start 1 cycle -> busy 1 for 11 cycles, done 1 cycle at edge 12, data_out=10'd255, err=0.
//  2. bcd_in=12'h999 -> data_out=10'h3E7; bcd_in=12'h000 -> data_out=0, err=0; both latency 12 edges.
//  3. bcd_in=12'h1A3 -> done at edge 2, err=1, data_out=0; next conversion 12'h007 -> err=0, data_out=7.
//  4. Second start pulse (bcd_in=12'h111) mid-SHIFT of 12'h042 -> ignored, data_out=42, single done.
//  5. rst asserted during SHIFT -> busy=0, data_out=0 immediately, no done; new start converts normally.
//  6. BCD2BIN_SIGNED_EN: sign_in=1, 12'h128 -> data_out=11'h780 (-128); sign_in=1, 12'h000 -> 11'h000;
//     defaults NUM_DIGITS=9/OUT_W=30: 36'h999999999 -> 30'd999999999.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one bit per clock.
// Optional BCD2BIN_SIGNED_EN adds sign_in and widens data_out to two's complement OUT_W+1 bits.
module bcd_to_binary #(
    parameter int unsigned NUM_DIGITS = 9,
    parameter int unsigned OUT_W      = 30
) (
    input  logic                    CLOCK_50,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
`ifdef BCD2BIN_SIGNED_EN
    input  logic                    sign_in,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    err,
`ifdef BCD2BIN_SIGNED_EN
    output logic [OUT_W:0]          data_out
`else
    output logic [OUT_W-1:0]        data_out
`endif
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned SR_W  = BCD_W + OUT_W;
    localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef BCD2BIN_SIGNED_EN
    localparam int unsigned DW    = OUT_W + 1;
`else
    localparam int unsigned DW    = OUT_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [SR_W-1:0]   sr, sr_n, step;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              busy_n, done_n, err_n;
    logic [DW-1:0]     data_n;
`ifdef BCD2BIN_SIGNED_EN
    logic              sign_q, sign_n;
    logic [DW-1:0]     mag_ext;
`endif

    // One reverse double-dabble step: shift {bcd,bin} right, then pull each digit >= 8 back by 3.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] s;
        s = v >> 1;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (s[OUT_W + 4*d + 3]) begin
                s[OUT_W + 4*d +: 4] = s[OUT_W + 4*d +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // State and output registers; outputs are loaded on the edge that enters DONE.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sr       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
`ifdef BCD2BIN_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            cnt      <= cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
            data_out <= data_n;
`ifdef BCD2BIN_SIGNED_EN
            sign_q   <= sign_n;
`endif
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        err_n   = err;
        data_n  = data_out;
        step    = dabble_step(sr);
`ifdef BCD2BIN_SIGNED_EN
        sign_n  = sign_q;
        mag_ext = {1'b0, step[OUT_W-1:0]};
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    sr_n    = {bcd_in, {OUT_W{1'b0}}};
`ifdef BCD2BIN_SIGNED_EN
                    sign_n  = sign_in;
`endif
                    busy_n  = 1'b1;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_n = '0;
                if (has_bad_digit(sr[SR_W-1:OUT_W])) begin
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    data_n  = '0;
                    state_n = S_DONE;
                end else begin
                    busy_n  = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_n = step;
                if (cnt == CNT_W'(OUT_W - 1)) begin
                    done_n  = 1'b1;
                    err_n   = 1'b0;
`ifdef BCD2BIN_SIGNED_EN
                    // Negating zero yields zero, so no negative zero can appear.
                    data_n  = sign_q ? (DW'(0) - mag_ext) : mag_ext;
`else
                    data_n  = step[OUT_W-1:0];
`endif
                    state_n = S_DONE;
                end else begin
                    busy_n = 1'b1;
                    cnt_n  = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed scenarios plus random conversions
// compared against an arithmetic decimal-to-binary model.
module tb_bcd_to_binary;

    localparam int unsigned ND  = 3;
    localparam int unsigned OW  = 10;
    localparam int unsigned BW  = 4 * ND;
`ifdef BCD2BIN_SIGNED_EN
    localparam bit          IS_SIGNED = 1'b1;
    localparam int unsigned DW  = OW + 1;
    localparam int unsigned DWW = 31;
`else
    localparam bit          IS_SIGNED = 1'b0;
    localparam int unsigned DW  = OW;
    localparam int unsigned DWW = 30;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sign_in;
    logic [BW-1:0] bcd_in;
    logic          busy, done, err;
    logic [DW-1:0] data_out;

    logic           start_w;
    logic [35:0]    bcd_w;
    logic           busy_w, done_w, err_w;
    logic [DWW-1:0] data_w;
`ifdef BCD2BIN_SIGNED_EN
    logic           sign_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_to_binary #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .start    (start),
        .bcd_in   (bcd_in),
`ifdef BCD2BIN_SIGNED_EN
        .sign_in  (sign_in),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err),
        .data_out (data_out)
    );

    bcd_to_binary dut_wide (
        .CLOCK_50 (clk),
        .rst      (rst),
        .start    (start_w),
        .bcd_in   (bcd_w),
`ifdef BCD2BIN_SIGNED_EN
        .sign_in  (sign_w),
`endif
        .busy     (busy_w),
        .done     (done_w),
        .err      (err_w),
        .data_out (data_w)
    );

    // Reference: decimal value of the digits by plain arithmetic, negated when signed.
    function automatic void model(input logic [BW-1:0] bcd, input logic sgn,
                                  output logic [DW-1:0] exp_data, output logic exp_err);
        int unsigned mag, w;
        logic [3:0]  dig;
        mag = 0;
        w   = 1;
        exp_err = 1'b0;
        for (int i = 0; i < int'(ND); i++) begin
            dig = bcd[4*i +: 4];
            if (dig > 4'd9) exp_err = 1'b1;
            mag += 32'(dig) * w;
            w   *= 10;
        end
        if (exp_err)                exp_data = '0;
        else if (sgn && IS_SIGNED)  exp_data = DW'(32'd0 - mag);
        else                        exp_data = DW'(mag);
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Pulses start for one edge; edges counts posedges from the capture edge to the done cycle.
    task automatic convert(input logic [BW-1:0] bcd, output int edges,
                           output int busy_cyc, output logic ok);
        wait_idle();
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        edges    = 1;
        busy_cyc = 0;
        ok       = 1'b0;
        while (!ok && edges < 100) begin
            if (done === 1'b1) begin
                ok = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cyc++;
                @(posedge clk); #1;
                edges++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bcd_in = '0; sign_in = 1'b0;
        start_w = 1'b0; bcd_w = '0;
`ifdef BCD2BIN_SIGNED_EN
        sign_w = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (data_out !== '0)   begin n_fail++; $display("FAIL reset_data: got %0h expected 0", data_out); end
        n_checks++; if (data_w !== '0)     begin n_fail++; $display("FAIL reset_data_wide: got %0h expected 0", data_w); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int e, b; logic ok;
        sign_in = 1'b0;
        convert(12'h255, e, b, ok);
        n_checks++; if (!ok)                  begin n_fail++; $display("FAIL basic_timeout: no done within bound"); end
        n_checks++; if (data_out !== DW'(255)) begin n_fail++; $display("FAIL basic_data: got %0d expected 255", data_out); end
        n_checks++; if (err !== 1'b0)         begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
        n_checks++; if (e != 12)              begin n_fail++; $display("FAIL basic_latency: got %0d edges expected 12", e); end
        n_checks++; if (b != 11)              begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 11", b); end
    endtask

    task automatic test_corners();
        int e, b; logic ok;
        sign_in = 1'b0;
        convert(12'h999, e, b, ok);
        n_checks++; if (!ok || data_out !== DW'(999)) begin n_fail++; $display("FAIL max_data: got %0d expected 999", data_out); end
        n_checks++; if (e != 12)                      begin n_fail++; $display("FAIL max_latency: got %0d expected 12", e); end
        convert(12'h000, e, b, ok);
        n_checks++; if (!ok || data_out !== '0)       begin n_fail++; $display("FAIL zero_data: got %0d expected 0", data_out); end
        n_checks++; if (err !== 1'b0)                 begin n_fail++; $display("FAIL zero_err: got %b expected 0", err); end
        n_checks++; if (e != 12)                      begin n_fail++; $display("FAIL zero_latency: got %0d expected 12", e); end
    endtask

    task automatic test_error();
        int e, b; logic ok;
        sign_in = 1'b1;
        convert(12'h1A3, e, b, ok);
        n_checks++; if (!ok || err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b expected 1", err); end
        n_checks++; if (data_out !== '0)     begin n_fail++; $display("FAIL err_data: got %0h expected 0", data_out); end
        n_checks++; if (e != 2)              begin n_fail++; $display("FAIL err_latency: got %0d expected 2", e); end
        sign_in = 1'b0;
        convert(12'h007, e, b, ok);
        n_checks++; if (!ok || err !== 1'b0)   begin n_fail++; $display("FAIL err_clear: got %b expected 0", err); end
        n_checks++; if (data_out !== DW'(7))   begin n_fail++; $display("FAIL err_next_data: got %0d expected 7", data_out); end
    endtask

    task automatic test_ignore_start();
        int dones; logic [DW-1:0] got;
        sign_in = 1'b0;
        wait_idle();
        bcd_in = 12'h042; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bcd_in = 12'h111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) got = data_out;
            end
        end
        n_checks++; if (dones != 1)      begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        n_checks++; if (got !== DW'(42)) begin n_fail++; $display("FAIL ignore_data: got %0d expected 42", got); end
    endtask

    task automatic test_reset_mid();
        int dones, e, b; logic ok;
        sign_in = 1'b0;
        wait_idle();
        bcd_in = 12'h555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL midrst_data: got %0h expected 0", data_out); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dones); end
        convert(12'h086, e, b, ok);
        n_checks++; if (!ok || data_out !== DW'(86)) begin n_fail++; $display("FAIL midrst_recover: got %0d expected 86", data_out); end
        n_checks++; if (e != 12)                     begin n_fail++; $display("FAIL midrst_latency: got %0d expected 12", e); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        sign_in = 1'b0;
        wait_idle();
        bcd_in = 12'h321; start = 1'b1;
        for (int i = 0; i < 60 && second < 0; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++; if (second < 0 || second - first != 13) begin n_fail++; $display("FAIL b2b_period: got %0d expected 13", second - first); end
        n_checks++; if (data_out !== DW'(321))              begin n_fail++; $display("FAIL b2b_data: got %0d expected 321", data_out); end
    endtask

    task automatic test_random();
        int e, b; logic ok;
        logic [BW-1:0] bcd;
        logic [DW-1:0] exp_d;
        logic          exp_e;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < int'(ND); i++) begin
                if ($urandom_range(0, 11) == 0) bcd[4*i +: 4] = 4'($urandom_range(10, 15));
                else                            bcd[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            sign_in = 1'($urandom_range(0, 1));
            model(bcd, sign_in, exp_d, exp_e);
            convert(bcd, e, b, ok);
            n_checks++; if (!ok || data_out !== exp_d) begin n_fail++; $display("FAIL rand_data bcd=%0h: got %0h expected %0h", bcd, data_out, exp_d); end
            n_checks++; if (err !== exp_e)             begin n_fail++; $display("FAIL rand_err bcd=%0h: got %b expected %b", bcd, err, exp_e); end
            n_checks++; if (e != (exp_e ? 2 : 12))     begin n_fail++; $display("FAIL rand_latency bcd=%0h: got %0d expected %0d", bcd, e, exp_e ? 2 : 12); end
            bcd_in = ~bcd;
            @(posedge clk); #1;
            n_checks++; if (done !== 1'b0 || data_out !== exp_d) begin n_fail++; $display("FAIL rand_hold bcd=%0h: done=%b data=%0h expected 0/%0h", bcd, done, data_out, exp_d); end
        end
    endtask

`ifdef BCD2BIN_SIGNED_EN
    task automatic test_signed();
        int e, b; logic ok;
        sign_in = 1'b1;
        convert(12'h128, e, b, ok);
        n_checks++; if (!ok || data_out !== 11'h780) begin n_fail++; $display("FAIL signed_neg: got %0h expected 780", data_out); end
        convert(12'h000, e, b, ok);
        n_checks++; if (!ok || data_out !== 11'h000) begin n_fail++; $display("FAIL signed_zero: got %0h expected 0", data_out); end
        sign_in = 1'b0;
    endtask
`endif

    task automatic test_wide_default();
        int e; logic ok;
        @(negedge clk);
        bcd_w = 36'h999999999; start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        e = 1; ok = 1'b0;
        while (!ok && e < 80) begin
            if (done_w === 1'b1) ok = 1'b1;
            else begin @(posedge clk); #1; e++; end
        end
        n_checks++; if (!ok || data_w !== DWW'(999999999)) begin n_fail++; $display("FAIL wide_data: got %0d expected 999999999", data_w); end
        n_checks++; if (err_w !== 1'b0 || e != 32)         begin n_fail++; $display("FAIL wide_latency_err: err=%b edges=%0d expected 0/32", err_w, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_error();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef BCD2BIN_SIGNED_EN
        test_signed();
`endif
        test_wide_default();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
